// File: rtl/axi_lite_seq_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : axi_lite_seq_master
//  Purpose  : AXI4-Lite self-test master. On a start edge it writes an
//             incrementing pattern to consecutive words, reads every word
//             back, compares, and reports sticky pass/fail status.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_seq_master #(
  parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h0000_0000,
  parameter int          C_M_AXI_ADDR_WIDTH   = 32,
  parameter int          C_M_AXI_DATA_WIDTH   = 32,
  parameter int          C_M_TRANSACTIONS_NUM = 4,
  parameter logic [31:0] C_M_START_DATA       = 32'h0000_0001
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            INIT_AXI_TXN,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [7:0]                      ERR_CNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]                      M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int                          AW       = C_M_AXI_ADDR_WIDTH;
  localparam int                          DW       = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0]               BASE     = AW'(C_M_TARGET_BASE_ADDR);
  // Index is 8 bits wide: up to 256 words per pass.
  localparam logic [7:0]                  LAST_IDX = 8'(C_M_TRANSACTIONS_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            init_q, init_d;        // registered copy of start request
  logic            armed_q, armed_d;      // start request seen low since reset
  logic [7:0]      idx_q, idx_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            txn_done_q, txn_done_d;
  logic            error_q, error_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            start;
  logic            aw_hs;
  logic            w_hs;
  logic            rd_fail;
  logic            last;
  logic [7:0]      idx_nxt;
  logic [7:0]      err_cnt_inc;

  // Address of word idx; wraps modulo 2^AW.
  function automatic logic [AW-1:0] addr_of(input logic [7:0] idx);
    return BASE + AW'({idx, 2'b00});
  endfunction

  // Pattern value for word idx; wraps modulo 2^32.
  function automatic logic [DW-1:0] data_of(input logic [7:0] idx);
    return DW'(C_M_START_DATA + 32'(idx));
  endfunction

  // Handshake and bookkeeping helpers shared by several states.
  always_comb begin
    start       = INIT_AXI_TXN && !init_q && armed_q;
    aw_hs       = awvalid_q && M_AXI_AWREADY;
    w_hs        = wvalid_q && M_AXI_WREADY;
    rd_fail     = (M_AXI_RDATA != data_of(idx_q)) || (M_AXI_RRESP != 2'b00);
    last        = (idx_q == LAST_IDX);
    idx_nxt     = idx_q + 8'd1;
    err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
  end

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    init_d     = INIT_AXI_TXN;
    armed_d    = armed_q | ~INIT_AXI_TXN;
    idx_d      = idx_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    txn_done_d = txn_done_q;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          txn_done_d = 1'b0;
          error_d    = 1'b0;
          err_cnt_d  = 8'd0;
          idx_d      = 8'd0;
          awaddr_d   = addr_of(8'd0);
          wdata_d    = data_of(8'd0);
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = S_WR_ADDR;
        end
      end

      S_WR_ADDR: begin
        // AW and W complete independently; leave once both have.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            error_d   = 1'b1;
            err_cnt_d = err_cnt_inc;
          end
          if (last) begin
            idx_d     = 8'd0;
            araddr_d  = addr_of(8'd0);
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end else begin
            idx_d     = idx_nxt;
            awaddr_d  = addr_of(idx_nxt);
            wdata_d   = data_of(idx_nxt);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_ADDR;
          end
        end
      end

      S_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          // Data and response failures on one beat count once.
          if (rd_fail) begin
            error_d   = 1'b1;
            err_cnt_d = err_cnt_inc;
          end
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_nxt;
            araddr_d  = addr_of(idx_nxt);
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end

      S_DONE: begin
        txn_done_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      init_q     <= 1'b0;
      armed_q    <= 1'b0;
      idx_q      <= 8'd0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      txn_done_q <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      armed_q    <= armed_d;
      idx_q      <= idx_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      txn_done_q <= txn_done_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign TXN_DONE      = txn_done_q;
  assign ERROR         = error_q;
  assign ERR_CNT       = err_cnt_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: doc/axi_lite_seq_master.md
# axi_lite_seq_master

Hardware AXI4-Lite master that sits directly upstream of the 4-register AXI4-Lite slave (S00_AXI) and drives its slave port. On a start request it writes an incrementing data pattern to consecutive word addresses, reads every word back, and compares each read against the written value. It produces sticky pass/fail status, so the slave path can be self-checked on silicon without a VIP.

## Interface
- C_M_TARGET_BASE_ADDR, 32'h0000_0000, byte address of the first word written/read
- C_M_AXI_ADDR_WIDTH, 32, AWADDR/ARADDR width
- C_M_AXI_DATA_WIDTH, 32, WDATA/RDATA width (only 32 supported)
- C_M_TRANSACTIONS_NUM, 4, words per pass (1..256)
- C_M_START_DATA, 32'h0000_0001, data written to word 0; word i gets C_M_START_DATA + i
- ACLK  in  1  sole clock; every signal is sampled on its rising edge
- ARESET  in  1  synchronous reset, active-high
- INIT_AXI_TXN  in  1  start request; its rising edge launches a pass
- TXN_DONE  out  1  high once a pass completes; held until the next accepted start
- ERROR  out  1  sticky mismatch/response error for the current pass
- ERR_CNT  out  8  count of failing beats in the current pass; saturates at 255
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH;  M_AXI_AWPROT out 3 (always 3'b000);  M_AXI_AWVALID out 1;  M_AXI_AWREADY in 1
- M_AXI_WDATA  out  32;  M_AXI_WSTRB out 4 (always 4'hF);  M_AXI_WVALID out 1;  M_AXI_WREADY in 1
- M_AXI_BRESP  in  2;  M_AXI_BVALID in 1;  M_AXI_BREADY out 1
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH;  M_AXI_ARPROT out 3 (always 3'b000);  M_AXI_ARVALID out 1;  M_AXI_ARREADY in 1
- M_AXI_RDATA  in  32;  M_AXI_RRESP in 2;  M_AXI_RVALID in 1;  M_AXI_RREADY out 1

## Operation
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: start = INIT_AXI_TXN high this cycle and low the previous cycle (edge detect on a registered copy). On start:
  - clear ERROR, ERR_CNT, TXN_DONE
  - index i = 0
  - go to WR_ADDR
- WR_ADDR:
  - assert AWVALID and WVALID together, with AWADDR = base + 4*i and WDATA = C_M_START_DATA + i.
  - Drop each VALID independently the cycle after its own handshake (VALID && READY).
  - When both handshakes are done, go to WR_RESP.
- WR_RESP:
  - BREADY high.
  - On BVALID: if BRESP != 2'b00, set ERROR and increment ERR_CNT.
  - If i = N-1, set i = 0 and go to RD_ADDR; else increment i and return to WR_ADDR.
- RD_ADDR:
  - ARVALID high with ARADDR = base + 4*i.
  - On ARREADY, go to RD_DATA.
- RD_DATA:
  - RREADY high.
  - On RVALID, the beat fails if RDATA != C_M_START_DATA + i or RRESP != 2'b00. A failing beat sets ERROR and increments ERR_CNT; a beat failing on both counts is counted once.
  - If i = N-1, go to DONE; else increment i and return to RD_ADDR.
- DONE: TXN_DONE = 1, then go to IDLE; TXN_DONE stays high in IDLE.
- Exactly one transaction is outstanding at any time. No write is issued before the previous B response has arrived, and no read before the previous R beat has arrived.
- Any start arriving while not in IDLE is ignored and is not queued.
- Data arithmetic is modulo 2^32. Address arithmetic is modulo 2^C_M_AXI_ADDR_WIDTH, so the address wraps silently.
- ERR_CNT holds at 8'hFF once it reaches 255.

## Timing
- Reset values:
  - all VALID/READY outputs 0
  - AWADDR, ARADDR, WDATA = 0
  - TXN_DONE, ERROR, ERR_CNT = 0
  - FSM = IDLE; edge-detect register = 0
- Reset asserted mid-pass: on the reset edge the FSM returns to IDLE and every output takes its reset value. No partial transaction is completed. An INIT_AXI_TXN held high across reset deassertion does not start a pass until it falls and rises again.
- VALID is never deasserted before its handshake.
- AW/W/AR address and data outputs are registered and stay stable while their VALID is high.
- Minimum latency with all READYs tied high and zero-latency B/R responses:
  - write: 2 cycles per word (WR_ADDR, WR_RESP)
  - read: 2 cycles per word (RD_ADDR, RD_DATA)
  - TXN_DONE rises 4N+2 cycles after the start edge (N = C_M_TRANSACTIONS_NUM; 18 cycles for N = 4)
- When AWREADY and WREADY arrive in different cycles, WR_ADDR exits the cycle after the later handshake.

## Test plan
- Basic pass, memory slave model with READYs tied high, N = 4:
  - stimulus: pulse INIT_AXI_TXN
  - required: writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then 4 reads; TXN_DONE=1 after 18 cycles; ERROR=0, ERR_CNT=0
- Split write handshake:
  - stimulus: AWREADY delayed 3 cycles, WREADY immediate
  - required: WVALID drops after 1 cycle; AWVALID held with stable AWADDR; WR_RESP entered only after both handshakes; pass still succeeds
- Corrupted read data:
  - stimulus: slave returns 0xDEAD for word 2
  - required: ERROR=1, ERR_CNT=1 at done, TXN_DONE=1; a rerun with a clean slave clears both
- Error responses:
  - stimulus: BRESP=SLVERR on word 1 and RRESP=SLVERR on word 3 with correct data
  - required: ERR_CNT=2, ERROR=1
- Reset mid-pass and restart:
  - stimulus: assert ARESET during the third write
  - required: all outputs return to reset values on the next edge; a fresh INIT_AXI_TXN edge runs a full pass from address 0
  - stimulus: second INIT_AXI_TXN edge while busy
  - required: ignored, exactly 4 writes and 4 reads occur
